fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's hazard, redirect, instruction-memory and IF/ID
// signals; clock and reset stay outside as plain ports.
interface fetch_stage_if #(
  parameter int DBITS               = 32,
  parameter int IMEM_ADDR_BIT_WIDTH = 11
);
  logic                           stall;
  logic                           redirect_valid;
  logic [DBITS-1:0]               redirect_pc;
  logic [31:0]                    imem_data;
  logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr;
  logic [DBITS-1:0]               if_pc;
  logic [DBITS-1:0]               if_pc_plus4;
  logic [31:0]                    if_inst;
  logic                           if_valid;
  logic                           fetch_fault;
  logic [31:0]                    fetch_count;

  // Driven side: hazard unit, execute redirect and instruction memory
  modport master (
    output stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, if_pc, if_pc_plus4, if_inst, if_valid, fetch_fault, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, if_pc, if_pc_plus4, if_inst, if_valid, fetch_fault, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// BOOT/RUN/STALLED/FAULT controller handling stalls and branch redirects.
module fetch_stage #(
  parameter int               DBITS               = 32,
  parameter logic [DBITS-1:0] START_PC            = DBITS'(32'h40),
  parameter int               IMEM_ADDR_BIT_WIDTH = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALLED = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] if_pc_q, if_pc_d;
  logic [31:0]      if_inst_q, if_inst_d;
  logic             if_valid_q, if_valid_d;
  logic             fault_q, fault_d;
  logic [31:0]      count_q, count_d;

  logic redirect_misaligned;
  assign redirect_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect always wins over stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = redirect_misaligned ? ST_FAULT : ST_RUN;
      end
      ST_RUN, ST_STALLED: begin
        if (bus.redirect_valid) begin
          state_d = redirect_misaligned ? ST_FAULT : ST_RUN;
        end else if (bus.stall) begin
          state_d = ST_STALLED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Datapath next values selected by the current state and inputs
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    count_d    = count_q;
    case (state_q)
      ST_BOOT: begin
        if_inst_d  = 32'h0;
        if_valid_d = 1'b0;
        if (redirect_misaligned) begin
          fault_d = 1'b1;
        end
      end
      ST_RUN, ST_STALLED: begin
        if (bus.redirect_valid) begin
          // Bubble keeps the old if_pc; only inst/valid are cleared
          if_inst_d  = 32'h0;
          if_valid_d = 1'b0;
          if (redirect_misaligned) begin
            fault_d = 1'b1;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (!bus.stall) begin
          pc_d       = pc_q + DBITS'(4);
          if_pc_d    = pc_q;
          if_inst_d  = bus.imem_data;
          if_valid_d = 1'b1;
          count_d    = count_q + 32'd1;
        end
      end
      default: begin
        if_inst_d  = 32'h0;
        if_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= START_PC;
      if_pc_q    <= START_PC;
      if_inst_q  <= 32'h0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  // Memory address comes from the registered PC only, never from redirect_pc
  assign bus.imem_addr   = pc_q[IMEM_ADDR_BIT_WIDTH+1:2];
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_q + DBITS'(4);
  assign bus.if_inst     = if_inst_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each stimulus step queues its hand-computed
// post-edge outputs, and a monitor compares them after every rising edge.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset_n;

  fetch_stage_if #(.DBITS(32), .IMEM_ADDR_BIT_WIDTH(11)) bus ();

  fetch_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory returns a tag plus the word address it was given
  assign bus.imem_data = 32'hA000_0000 | {21'h0, bus.imem_addr};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
    logic        fault;
    logic [10:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " if_pc"},       bus.if_pc, 32'h40);
    chk({tag, " if_inst"},     bus.if_inst, 32'h0);
    chk({tag, " if_valid"},    {31'h0, bus.if_valid}, 32'h0);
    chk({tag, " fetch_fault"}, {31'h0, bus.fetch_fault}, 32'h0);
    chk({tag, " fetch_count"}, bus.fetch_count, 32'h0);
    chk({tag, " imem_addr"},   {21'h0, bus.imem_addr}, 32'h10);
    $display("reset check %s: if_pc=%h valid=%0b fault=%0b cnt=%0d addr=%h",
             tag, bus.if_pc, bus.if_valid, bus.fetch_fault, bus.fetch_count, bus.imem_addr);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_valid,
                      input logic [31:0] e_cnt, input logic e_fault, input logic [10:0] e_addr);
    exp_t e;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    e.pc = e_pc; e.inst = e_inst; e.valid = e_valid;
    e.cnt = e_cnt; e.fault = e_fault; e.addr = e_addr;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one queued expectation per rising edge
  initial begin
    exp_t e;
    logic [31:0] plus4;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        plus4 = e.pc + 32'd4;
        txn++;
        chk("if_pc",       bus.if_pc, e.pc);
        chk("if_pc_plus4", bus.if_pc_plus4, plus4);
        chk("if_inst",     bus.if_inst, e.inst);
        chk("if_valid",    {31'h0, bus.if_valid}, {31'h0, e.valid});
        chk("fetch_count", bus.fetch_count, e.cnt);
        chk("fetch_fault", {31'h0, bus.fetch_fault}, {31'h0, e.fault});
        chk("imem_addr",   {21'h0, bus.imem_addr}, {21'h0, e.addr});
        $display("txn %0d: if_pc=%h inst=%h valid=%0b cnt=%0d fault=%0b addr=%h",
                 txn, bus.if_pc, bus.if_inst, bus.if_valid, bus.fetch_count,
                 bus.fetch_fault, bus.imem_addr);
      end
    end
  end

  initial begin
    reset_n            = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(negedge clk);
    #1;
    check_reset("power-on");
    @(negedge clk);
    reset_n = 1'b1;

    // Boot bubble, then sequential fetch from 0x40
    step(0, 0, 32'h0, 32'h40, 32'h0,        0, 0, 0, 11'h010);
    step(0, 0, 32'h0, 32'h40, 32'hA0000010, 1, 1, 0, 11'h011);
    step(0, 0, 32'h0, 32'h44, 32'hA0000011, 1, 2, 0, 11'h012);
    // Three-cycle stall at pc=0x48, then resume
    step(1, 0, 32'h0, 32'h44, 32'hA0000011, 1, 2, 0, 11'h012);
    step(1, 0, 32'h0, 32'h44, 32'hA0000011, 1, 2, 0, 11'h012);
    step(1, 0, 32'h0, 32'h44, 32'hA0000011, 1, 2, 0, 11'h012);
    step(0, 0, 32'h0, 32'h48, 32'hA0000012, 1, 3, 0, 11'h013);
    // Redirect beats a simultaneous stall
    step(1, 1, 32'h100, 32'h48,  32'h0,        0, 3, 0, 11'h040);
    step(0, 0, 32'h0,   32'h100, 32'hA0000040, 1, 4, 0, 11'h041);
    step(0, 0, 32'h0,   32'h104, 32'hA0000041, 1, 5, 0, 11'h042);
    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFFFFFC, 32'h104,      32'h0,        0, 5, 0, 11'h7FF);
    step(0, 0, 32'h0,        32'hFFFFFFFC, 32'hA00007FF, 1, 6, 0, 11'h000);
    step(0, 0, 32'h0,        32'h0,        32'hA0000000, 1, 7, 0, 11'h001);
    // Misaligned redirect enters FAULT; later stimulus is ignored
    step(0, 1, 32'h102, 32'h0, 32'h0, 0, 7, 1, 11'h001);
    step(0, 0, 32'h0,   32'h0, 32'h0, 0, 7, 1, 11'h001);
    step(0, 1, 32'h200, 32'h0, 32'h0, 0, 7, 1, 11'h001);
    step(1, 0, 32'h0,   32'h0, 32'h0, 0, 7, 1, 11'h001);

    // Reset clears FAULT asynchronously
    #2 reset_n = 1'b0;
    #1 check_reset("fault-reset");
    reset_n = 1'b1;
    step(0, 0, 32'h0, 32'h40, 32'h0,        0, 0, 0, 11'h010);
    step(0, 0, 32'h0, 32'h40, 32'hA0000010, 1, 1, 0, 11'h011);
    step(1, 0, 32'h0, 32'h40, 32'hA0000010, 1, 1, 0, 11'h011);

    // Reset pulse between edges while stalled takes effect without a clock
    bus.stall = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset("stall-reset");
    reset_n = 1'b1;
    step(0, 0, 32'h0, 32'h40, 32'h0,        0, 0, 0, 11'h010);
    step(0, 0, 32'h0, 32'h40, 32'hA0000010, 1, 1, 0, 11'h011);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
